// File: rtl/l1_msi_cache.sv
// Direct-mapped, one-word-per-line L1 cache with MSI coherence.
// Core misses are served by a bus FSM, and other caches' bus traffic is snooped.
module l1_msi_cache #(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        read,
    input  logic        write,
    input  logic [8:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] fetched_data,
    output logic        stall_cpu,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [1:0]  bus_cmd,
    output logic [8:0]  bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_done,
    input  logic        snoop_valid,
    input  logic [1:0]  snoop_cmd,
    input  logic [8:0]  snoop_addr,
    output logic        snoop_flush,
    output logic [31:0] snoop_data
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 9 - IDX_W;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_RD    = 2'b01;
    localparam logic [1:0] CMD_RDX   = 2'b10;
    localparam logic [1:0] CMD_FLUSH = 2'b11;

    typedef enum logic [1:0] {ST_I, ST_S, ST_M} line_state_t;
    typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} fsm_t;

    line_state_t             state_q [LINES];
    logic        [TAG_W-1:0] tag_q   [LINES];
    logic        [31:0]      data_q  [LINES];
    fsm_t                    fsm_q, fsm_d;

    logic [IDX_W-1:0] idx, sidx;
    logic [TAG_W-1:0] tag, stag;
    logic             req, core_hit, victim_dirty, core_go;
    logic             snoop_on, snoop_hit, snoop_is_m, snoop_clash, snoop_flush_c;
    logic [1:0]       fill_cmd;

    assign idx  = address[IDX_W-1:0];
    assign tag  = address[8:IDX_W];
    assign sidx = snoop_addr[IDX_W-1:0];
    assign stag = snoop_addr[8:IDX_W];

    assign req          = read | write;
    assign fill_cmd     = write ? CMD_RDX : CMD_RD;
    assign core_hit     = (state_q[idx] != ST_I) && (tag_q[idx] == tag) &&
                          (!write || state_q[idx] == ST_M);
    assign victim_dirty = (state_q[idx] == ST_M) && (tag_q[idx] != tag);

    assign snoop_on      = snoop_valid && !bus_grant;
    assign snoop_hit     = snoop_on && (state_q[sidx] != ST_I) && (tag_q[sidx] == stag);
    assign snoop_is_m    = state_q[sidx] == ST_M;
    assign snoop_flush_c = snoop_hit && snoop_is_m &&
                           (snoop_cmd == CMD_RD || snoop_cmd == CMD_RDX);
    // Any live snoop on the core's index takes the cycle; the core retries next cycle.
    assign snoop_clash   = snoop_on && (sidx == idx);
    assign core_go       = (fsm_q == IDLE) && req && !snoop_clash && !resetn;

    assign fetched_data = resetn ? 32'd0 : data_q[idx];
    assign snoop_flush  = !resetn && snoop_flush_c;
    assign snoop_data   = snoop_flush ? data_q[sidx] : 32'd0;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        fsm_d     = fsm_q;
        stall_cpu = 1'b1;
        bus_req   = 1'b0;
        bus_cmd   = CMD_NONE;
        bus_addr  = 9'd0;
        bus_wdata = 32'd0;
        if (resetn) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    stall_cpu = req && !(core_go && core_hit);
                    if (core_go && !core_hit)
                        fsm_d = victim_dirty ? WB_REQ : FILL_REQ;
                end
                WB_REQ: begin
                    // A snoop may have already downgraded the victim, so nothing is left to write back.
                    if (state_q[idx] != ST_M) begin
                        fsm_d = FILL_REQ;
                    end else begin
                        bus_req = 1'b1;
                        if (bus_grant) begin
                            bus_cmd   = CMD_FLUSH;
                            bus_addr  = {tag_q[idx], idx};
                            bus_wdata = data_q[idx];
                            fsm_d     = WB_WAIT;
                        end
                    end
                end
                WB_WAIT: begin
                    bus_req   = 1'b1;
                    bus_cmd   = CMD_FLUSH;
                    bus_addr  = {tag_q[idx], idx};
                    bus_wdata = data_q[idx];
                    if (bus_done) fsm_d = FILL_REQ;
                end
                FILL_REQ: begin
                    bus_req = 1'b1;
                    if (bus_grant) begin
                        bus_cmd  = fill_cmd;
                        bus_addr = address;
                        fsm_d    = FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    bus_req  = 1'b1;
                    bus_cmd  = fill_cmd;
                    bus_addr = address;
                    if (bus_done) fsm_d = IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            fsm_q <= IDLE;
            // NOTE: the line arrays are reset explicitly because tags and data must read back as zero.
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= ST_I;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            fsm_q <= fsm_d;
            if (snoop_hit) begin
                if (snoop_cmd == CMD_RD && snoop_is_m) state_q[sidx] <= ST_S;
                else if (snoop_cmd == CMD_RDX)         state_q[sidx] <= ST_I;
            end
            if (core_go && core_hit && write) data_q[idx] <= write_data;
            if (fsm_q == WB_WAIT && bus_done) state_q[idx] <= ST_I;
            if (fsm_q == FILL_WAIT && bus_done) begin
                state_q[idx] <= write ? ST_M : ST_S;
                tag_q[idx]   <= tag;
                data_q[idx]  <= bus_rdata;
            end
        end
    end
endmodule

// File: doc/l1_msi_cache.md
L1_MSI_CACHE -- requirements
Module: l1_msi_cache

Interface
REQ-001 Parameter: LINES, 8, number of direct-mapped one-word lines (power of 2, 2..64); index = address[log2(LINES)-1:0], tag = remaining upper address bits.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 resetn  in  1  synchronous, active-high reset.
REQ-004 read  in  1  core read request (level); write  in  1  core write request (level); both high is treated as write.
REQ-005 address  in  9  core word address; write_data  in  32  core store data.
REQ-006 fetched_data  out  32  load data to core; stall_cpu  out  1  high = current core request not completed this cycle.
REQ-007 bus_req  out  1  bus arbitration request; bus_grant  in  1  bus ownership, held by arbiter until bus_done.
REQ-008 bus_cmd  out  2  00 none, 01 BusRd, 10 BusRdX, 11 Flush; bus_addr  out  9; bus_wdata  out  32 (Flush data).
REQ-009 bus_rdata  in  32  fill data; bus_done  in  1  one-cycle pulse ending the current bus transaction.
REQ-010 snoop_valid  in  1; snoop_cmd  in  2 (encoding as bus_cmd); snoop_addr  in  9  other caches' bus transactions.
REQ-011 snoop_flush  out  1  this cache supplies data for snooped address; snoop_data  out  32  that data.

Function
REQ-012 Per line: state {I,S,M}, tag, 32-bit data; no other storage.
REQ-013 FSM states: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT.
REQ-014 Hit = line state != I and tag match; read hit needs S or M; write hit needs M.
REQ-015 IDLE read hit: stall_cpu=0 same cycle, fetched_data = line data combinationally; no state change.
REQ-016 IDLE write hit: stall_cpu=0 same cycle; line data <= write_data at the edge; state stays M.
REQ-017 IDLE miss (incl. write to S line): stall_cpu=1; go to WB_REQ if victim is M with different tag, else FILL_REQ.
REQ-018 WB_REQ: bus_req=1; on bus_grant drive bus_cmd=Flush, bus_addr={victim tag,index}, bus_wdata=victim data; go WB_WAIT.
REQ-019 WB_WAIT: hold bus outputs; on bus_done victim line <= I, go FILL_REQ.
REQ-020 FILL_REQ: bus_req=1; on bus_grant drive bus_cmd=BusRd (read) or BusRdX (write), bus_addr=address; go FILL_WAIT.
REQ-021 FILL_WAIT: on bus_done install tag, data=bus_rdata, state S (read) or M (write); return IDLE; request then hits (REQ-015/016) next cycle.
REQ-022 stall_cpu=1 in every non-IDLE state; bus_req=0 and bus_cmd=00 whenever not in a bus state holding grant.
REQ-023 Core request address/type must remain stable while stall_cpu=1; block samples them live, no internal latching.
REQ-024 Snoop (snoop_valid=1, bus_grant=0) on matching valid line: BusRd on M -> snoop_flush=1, snoop_data=line data, state <= S; BusRdX on M -> flush, state <= I; BusRdX on S -> I; Flush or non-match -> no action.
REQ-025 Snoops ignored while bus_grant=1 (own transaction).
REQ-026 Simultaneous snoop and IDLE core access to the same index: snoop applied first; stall_cpu=1 that cycle; core retried next cycle.
REQ-027 Snoop matching the line being filled in FILL_WAIT: no action (line still I).
REQ-028 bus_done outside WB_WAIT/FILL_WAIT is ignored.

Reset
REQ-029 While resetn=1 at an edge: all lines <= I, tags and data <= 0, FSM <= IDLE.
REQ-030 While resetn=1: stall_cpu=1, fetched_data=0, bus_req=0, bus_cmd=00, bus_addr=0, bus_wdata=0, snoop_flush=0, snoop_data=0.
REQ-031 Reset mid-transaction abandons it immediately; no Flush issued; bus_req deasserted same cycle.

Verification
REQ-032 After reset, read 0x005 -> stall_cpu=1, BusRd addr 0x005; bus_rdata=0xDEADBEEF, bus_done -> next cycle stall_cpu=0, fetched_data=0xDEADBEEF, line 5 = S.
REQ-033 Write 0x005 data 0x11111111 on S line -> BusRdX addr 0x005; after bus_done line M, data 0x11111111, stall_cpu=0 for one cycle.
REQ-034 Read 0x00D (LINES=8, same index as dirty 0x005) -> Flush addr 0x005 data 0x11111111, then BusRd addr 0x00D; line 5 = S with new tag.
REQ-035 Line 3 M data 0xA5A5A5A5; snoop BusRd 0x003 -> snoop_flush=1, snoop_data=0xA5A5A5A5, line 3 = S; then snoop BusRdX 0x003 -> line 3 = I, snoop_flush=0.
REQ-036 Snoop BusRdX 0x003 same cycle as core read hit 0x003 -> stall_cpu=1, line I, next cycle BusRd issued.
REQ-037 Assert resetn during FILL_WAIT -> bus_req=0, stall_cpu=1, all lines I after edge; late bus_done ignored.
